// File: rtl/led_controller_pkg.sv
// Shared definitions for the LED pattern sequencer.
//   - DEF_* : default parameter values used by the sequencer and its prescaler
//   - seq_state_e : sequencer FSM states
// Optional feature macro: LED_PATTERN_SEQUENCER_CHASE_EN (used by the top).
package led_controller_pkg;

    localparam int DEF_NUM_LEDS       = 4;
    localparam int DEF_PWM_WIDTH      = 8;
    localparam int DEF_PRESCALE_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/led_prescaler.sv
// Tick generator for the LED sequencer.
// Ports:
//   ACLK, ARESETN : clock, synchronous active-low reset
//   active        : count only while high; held at zero otherwise
//   prescale      : tick every prescale+1 cycles
//   tick          : combinational one-cycle tick when the count reaches prescale
module led_prescaler
    import led_controller_pkg::*;
#(
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      active,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        // The live divider is compared with >= so that lowering it below the
        // current count wraps on the next cycle instead of running to overflow.
        tick  = active && (cnt_q >= prescale);
        cnt_d = cnt_q;
        if (!active || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED PWM pattern sequencer with IDLE/RUN/DRAIN control.
// Ports:
//   ACLK, ARESETN : sole clock, synchronous active-low reset
//   cfg_enable    : run the sequencer (dropping it drains to the frame end)
//   cfg_chase     : rotate the duty pattern one LED per frame
//   cfg_prescale  : PWM tick every cfg_prescale+1 cycles
//   cfg_duty      : per-LED duty, LED i in [i*PWM_WIDTH +: PWM_WIDTH]
//   led_out       : registered PWM drive
//   frame_done    : one-cycle pulse after the PWM counter wraps
//   busy          : high in RUN or DRAIN
// Optional feature: chase mode is built only when
// LED_PATTERN_SEQUENCER_CHASE_EN is defined; otherwise cfg_chase is ignored.
module led_pattern_sequencer
    import led_controller_pkg::*;
#(
    parameter int NUM_LEDS       = DEF_NUM_LEDS,
    parameter int PWM_WIDTH      = DEF_PWM_WIDTH,
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          cfg_enable,
    input  logic                          cfg_chase,
    input  logic [PRESCALE_WIDTH-1:0]     cfg_prescale,
    input  logic [NUM_LEDS*PWM_WIDTH-1:0] cfg_duty,
    output logic [NUM_LEDS-1:0]           led_out,
    output logic                          frame_done,
    output logic                          busy
);

    localparam int DUTY_BITS = NUM_LEDS * PWM_WIDTH;

    seq_state_e                         state_q, state_d;
    logic [PWM_WIDTH-1:0]               pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0][PWM_WIDTH-1:0] shadow_q, shadow_d;
    logic [NUM_LEDS-1:0]                led_q, led_d;
    logic                               frame_done_q, frame_done_d;

    logic                               active;
    logic                               tick;
    logic                               wrap;
    logic                               chase_on;
    logic [DUTY_BITS-1:0]               shadow_flat;
    logic [DUTY_BITS-1:0]               shadow_rot;

`ifdef LED_PATTERN_SEQUENCER_CHASE_EN
    assign chase_on = cfg_chase;
`else
    logic unused_cfg_chase;
    assign unused_cfg_chase = cfg_chase;
    assign chase_on         = 1'b0;
`endif

    assign active = (state_q != ST_IDLE);
    assign wrap   = tick && (pwm_cnt_q == '1);

    // Rotate by one LED slot: LED i takes LED i-1, LED 0 takes the top LED.
    assign shadow_flat = shadow_q;
    assign shadow_rot  = (shadow_flat << PWM_WIDTH)
                       | (shadow_flat >> ((NUM_LEDS - 1) * PWM_WIDTH));

    led_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .active   (active),
        .prescale (cfg_prescale),
        .tick     (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cfg_enable) state_d = ST_RUN;
            ST_RUN:   if (!cfg_enable) state_d = ST_DRAIN;
            // Re-enable wins over the wrap so a restart never passes through IDLE.
            ST_DRAIN: begin
                if (cfg_enable) begin
                    state_d = ST_RUN;
                end else if (wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        pwm_cnt_d = pwm_cnt_q;
        if (!active) begin
            pwm_cnt_d = '0;
        end else if (tick) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
        end

        // Shadow only changes in IDLE or on the frame boundary, so a duty
        // written mid-frame cannot cut a PWM period short.
        shadow_d = shadow_q;
        if (!active) begin
            shadow_d = cfg_duty;
        end else if (wrap) begin
            shadow_d = chase_on ? shadow_rot : cfg_duty;
        end

        for (int i = 0; i < NUM_LEDS; i++) begin
            led_d[i] = active && (pwm_cnt_q < shadow_q[i]);
        end

        frame_done_d = wrap;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= ST_IDLE;
            pwm_cnt_q    <= '0;
            shadow_q     <= '0;
            led_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwm_cnt_q    <= pwm_cnt_d;
            shadow_q     <= shadow_d;
            led_q        <= led_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign led_out    = led_q;
    assign frame_done = frame_done_q;
    assign busy       = active;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer. Expected frame periods and
// per-LED on-times come from the PWM arithmetic: a frame is 256*(P+1) cycles
// and an LED with duty d is lit d*(P+1) of them.
module tb_led_pattern_sequencer;

    localparam int NL  = 4;
    localparam int PW  = 8;
    localparam int PSW = 16;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic            cfg_enable = 1'b0;
    logic            cfg_chase = 1'b0;
    logic [PSW-1:0]  cfg_prescale = '0;
    logic [NL*PW-1:0] cfg_duty = '0;
    logic [NL-1:0]   led_out;
    logic            frame_done;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;
    int period;
    int busy_lo;
    int on_cnt[NL];
    int exp_d[NL];

    always #5 ACLK = ~ACLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    led_pattern_sequencer #(
        .NUM_LEDS       (NL),
        .PWM_WIDTH      (PW),
        .PRESCALE_WIDTH (PSW)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .cfg_enable   (cfg_enable),
        .cfg_chase    (cfg_chase),
        .cfg_prescale (cfg_prescale),
        .cfg_duty     (cfg_duty),
        .led_out      (led_out),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic load_duty();
        for (int i = 0; i < NL; i++) cfg_duty[i*PW +: PW] = PW'(exp_d[i]);
    endtask

    task automatic rand_duty();
        for (int i = 0; i < NL; i++) exp_d[i] = int'($urandom_range(0, 255));
        load_duty();
    endtask

    // Chase model: LED i takes LED i-1, LED 0 takes the top LED.
    task automatic rotate_model();
        int top;
        top = exp_d[NL-1];
        for (int i = NL - 1; i > 0; i--) exp_d[i] = exp_d[i-1];
        exp_d[0] = top;
    endtask

    task automatic wait_fd(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge ACLK);
            ok = (frame_done === 1'b1);
        end
        chk(tag, ok, 1);
    endtask

    task automatic go_idle();
        bit ok;
        ok = 1'b0;
        cfg_enable = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge ACLK);
            ok = (busy === 1'b0);
        end
        chk("go_idle", ok, 1);
    endtask

    // Starts on a frame_done cycle, ends on the next one. Optionally rewrites
    // LED0's duty chg_at cycles into the frame.
    task automatic measure_frame(input int budget, input int chg_at, input int chg_val);
        period  = 0;
        busy_lo = 0;
        for (int i = 0; i < NL; i++) on_cnt[i] = 0;
        do begin
            for (int i = 0; i < NL; i++) on_cnt[i] += int'(led_out[i]);
            if (busy !== 1'b1) busy_lo++;
            period++;
            if (period == chg_at) cfg_duty[PW-1:0] = PW'(chg_val);
            @(negedge ACLK);
        end while (frame_done !== 1'b1 && period < budget);
    endtask

    task automatic check_frame(input string tag, input int p, input int chg_at, input int chg_val);
        measure_frame(256 * (p + 1) + 16, chg_at, chg_val);
        chk($sformatf("%s.period", tag), period, 256 * (p + 1));
        chk($sformatf("%s.busy_low", tag), busy_lo, 0);
        for (int i = 0; i < NL; i++)
            chk($sformatf("%s.on%0d", tag, i), on_cnt[i], exp_d[i] * (p + 1));
    endtask

    initial begin
        int p;
        int bad;

        // Reset held with enable high: everything stays quiet.
        cfg_enable   = 1'b1;
        cfg_prescale = '0;
        exp_d = '{0, 'h40, 'h80, 'hFF};
        load_duty();
        for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            chk("rst.led", led_out, 0);
            chk("rst.busy", busy, 0);
            chk("rst.fd", frame_done, 0);
        end
        ARESETN = 1'b1;

        // Static PWM, tick every cycle.
        wait_fd("static.sync", 600);
        check_frame("static.f1", 0, -1, 0);
        check_frame("static.f2", 0, -1, 0);

        // Prescaler divide-by-4.
        go_idle();
        cfg_prescale = 16'd3;
        exp_d = '{'h80, 0, 0, 0};
        load_duty();
        cfg_enable = 1'b1;
        wait_fd("pre.sync", 2200);
        check_frame("pre", 3, -1, 0);

        // Random prescale and duties.
        for (int it = 0; it < 5; it++) begin
            go_idle();
            p = int'($urandom_range(0, 3));
            cfg_prescale = PSW'(p);
            rand_duty();
            cfg_enable = 1'b1;
            wait_fd($sformatf("rnd%0d.sync", it), 2200);
            check_frame($sformatf("rnd%0d", it), p, -1, 0);
        end

        // Mid-frame duty change lands on the next frame only.
        go_idle();
        cfg_prescale = '0;
        rand_duty();
        exp_d[0] = 'h10;
        load_duty();
        cfg_enable = 1'b1;
        wait_fd("glitch.sync", 600);
        check_frame("glitch.cur", 0, 50, 'hF0);
        exp_d[0] = 'hF0;
        check_frame("glitch.next", 0, -1, 0);

`ifdef LED_PATTERN_SEQUENCER_CHASE_EN
        go_idle();
        cfg_chase = 1'b1;
        exp_d = '{'hFF, 0, 0, 0};
        load_duty();
        cfg_enable = 1'b1;
        wait_fd("chase.sync", 600);
        for (int k = 1; k <= 4; k++) begin
            rotate_model();
            check_frame($sformatf("chase.f%0d", k), 0, -1, 0);
        end
        // Leaving chase: frame already started is rotated, next one reloads.
        cfg_chase = 1'b0;
        for (int i = 0; i < NL; i++) cfg_duty[i*PW +: PW] = PW'($urandom_range(0, 255));
        rotate_model();
        check_frame("chase.leave", 0, -1, 0);
        for (int i = 0; i < NL; i++) exp_d[i] = int'(cfg_duty[i*PW +: PW]);
        check_frame("chase.reload", 0, -1, 0);
        go_idle();
`else
        go_idle();
        cfg_chase = 1'b1;
        rand_duty();
        cfg_enable = 1'b1;
        wait_fd("nochase.sync", 600);
        check_frame("nochase.f1", 0, -1, 0);
        check_frame("nochase.f2", 0, -1, 0);
        go_idle();
`endif
        cfg_chase = 1'b0;

        // Drain: drop enable at pwm_cnt=100, busy until the wrap, then IDLE.
        rand_duty();
        cfg_enable = 1'b1;
        wait_fd("drain.sync", 600);
        repeat (100) @(negedge ACLK);
        cfg_enable = 1'b0;
        bad = 0;
        for (int k = 101; k <= 255; k++) begin
            @(negedge ACLK);
            if (busy !== 1'b1 || frame_done !== 1'b0) bad++;
        end
        chk("drain.busy_hold", bad, 0);
        @(negedge ACLK);
        chk("drain.fd", frame_done, 1);
        chk("drain.idle", busy, 0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            if (led_out !== '0 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        chk("drain.quiet", bad, 0);

        // Re-enable on the wrap cycle: straight back to RUN from pwm_cnt=0.
        cfg_enable = 1'b1;
        wait_fd("rearm.sync", 600);
        repeat (100) @(negedge ACLK);
        cfg_enable = 1'b0;
        repeat (155) @(negedge ACLK);
        cfg_enable = 1'b1;
        @(negedge ACLK);
        chk("rearm.fd", frame_done, 1);
        chk("rearm.busy", busy, 1);
        check_frame("rearm.f", 0, -1, 0);

        // Reset mid-frame abandons the frame with no pulse.
        repeat (77) @(negedge ACLK);
        ARESETN = 1'b0;
        cfg_enable = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            if (led_out !== '0 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        chk("midrst.quiet", bad, 0);
        ARESETN = 1'b1;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge ACLK);
            if (frame_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("midrst.nopulse", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
